// File: rtl/pattern_detector.sv
// pattern_detector
//   Serial bit-pattern detector with a programmable pattern and a saturating
//   match counter.
//
//   Ports
//     clk        clock, all state changes on the rising edge
//     rst        synchronous active-high reset
//     en         x carries a valid serial bit this cycle
//     x          serial data bit
//     pat_load   replace the active pattern with pat_in
//     pat_in     new pattern, bit PAT_LEN-1 is the first bit of the sequence
//     clr_cnt    clear the match counter
//     match      registered one-cycle pulse per detected pattern
//     match_cnt  registered saturating count of matches
//     pattern    currently active pattern
module pattern_detector #(
  parameter int                 PAT_LEN = 4,
  parameter int                 CNT_W   = 8,
  parameter int                 OVERLAP = 1,
  parameter logic [PAT_LEN-1:0] PAT_RST = 4'b1101
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               x,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               clr_cnt,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [PAT_LEN-1:0] pattern
);

  // fill counts valid history bits; it stops at PAT_LEN-1 ("history full").
  localparam int            FW       = $clog2(PAT_LEN);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN - 1);

  logic [PAT_LEN-2:0] hist_r;
  logic [FW-1:0]      fill_r;
  logic [PAT_LEN-1:0] pattern_r;
  logic               match_r;
  logic [CNT_W-1:0]   match_cnt_r;

  logic [PAT_LEN-1:0] window_s;
  logic               full_s;
  logic               hit_s;

  // Match condition: a full window equal to the pattern. A pattern load in
  // the same cycle discards the incoming bit, so it suppresses the hit.
  always_comb begin
    window_s = {hist_r, x};
    full_s   = (fill_r == FILL_MAX);
    hit_s    = en & ~pat_load & full_s & (window_s == pattern_r);
  end

  // Pattern, history, match pulse and counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_r   <= PAT_RST;
      hist_r      <= '0;
      fill_r      <= '0;
      match_r     <= 1'b0;
      match_cnt_r <= '0;
    end else begin
      match_r <= hit_s;

      // A clear coinciding with a hit counts that hit, so the result is 1.
      if (clr_cnt) begin
        match_cnt_r <= hit_s ? CNT_W'(1'b1) : '0;
      end else if (hit_s && (match_cnt_r != {CNT_W{1'b1}})) begin
        match_cnt_r <= match_cnt_r + CNT_W'(1'b1);
      end else begin
        match_cnt_r <= match_cnt_r;
      end

      if (pat_load) begin
        pattern_r <= pat_in;
        fill_r    <= '0;
      end else if (en) begin
        // History always shifts; in non-overlapping mode its contents are
        // irrelevant after a hit because fill restarts from zero.
        hist_r <= window_s[PAT_LEN-2:0];
        if (hit_s && (OVERLAP == 0)) begin
          fill_r <= '0;
        end else if (full_s) begin
          fill_r <= fill_r;
        end else begin
          fill_r <= fill_r + FW'(1'b1);
        end
      end else begin
        fill_r <= fill_r;
      end
    end
  end

  assign match     = match_r;
  assign match_cnt = match_cnt_r;
  assign pattern   = pattern_r;

endmodule

// File: tb/tb_pattern_detector.sv
// Testbench for pattern_detector. Three instances share one stimulus stream:
//   a: OVERLAP=1, CNT_W=8   b: OVERLAP=0, CNT_W=8   c: OVERLAP=1, CNT_W=2
// The reference model records every accepted bit in a flat log; each instance
// has a "segment start" index marking where usable history begins (moved by
// reset, pattern load and non-overlapping matches). A match is the last
// PAT_LEN logged bits of the current segment equalling the pattern.
module tb_pattern_detector;

  logic       clk = 1'b0;
  logic       rst, en, x, pat_load, clr_cnt;
  logic [3:0] pat_in;

  logic       match_a, match_b, match_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic [3:0] pat_a, pat_b, pat_c;

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit       bits [4096];
  int       nbits;
  int       seg   [3];
  int       cnt_m [3];
  int       em    [3];
  int       ov    [3] = '{1, 0, 1};
  int       cmax  [3] = '{255, 255, 3};
  logic [3:0] pat_m;

  always #5 clk = ~clk;

  pattern_detector #(.PAT_LEN(4), .CNT_W(8), .OVERLAP(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .x(x), .pat_load(pat_load), .pat_in(pat_in),
    .clr_cnt(clr_cnt), .match(match_a), .match_cnt(cnt_a), .pattern(pat_a));

  pattern_detector #(.PAT_LEN(4), .CNT_W(8), .OVERLAP(0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .x(x), .pat_load(pat_load), .pat_in(pat_in),
    .clr_cnt(clr_cnt), .match(match_b), .match_cnt(cnt_b), .pattern(pat_b));

  pattern_detector #(.PAT_LEN(4), .CNT_W(2), .OVERLAP(1)) dut_c (
    .clk(clk), .rst(rst), .en(en), .x(x), .pat_load(pat_load), .pat_in(pat_in),
    .clr_cnt(clr_cnt), .match(match_c), .match_cnt(cnt_c), .pattern(pat_c));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model at the edge, then compare.
  task automatic step(input bit r, input bit e, input bit xb, input bit ld,
                      input logic [3:0] pin, input bit clr);
    int hit [3];
    rst = r; en = e; x = xb; pat_load = ld; pat_in = pin; clr_cnt = clr;
    @(posedge clk);
    if (r) begin
      pat_m = 4'b1101;
      for (int i = 0; i < 3; i++) begin
        seg[i] = nbits; cnt_m[i] = 0; em[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) hit[i] = 0;
      if (ld) begin
        pat_m = pin;
        for (int i = 0; i < 3; i++) seg[i] = nbits;
      end else if (e) begin
        bits[nbits] = xb;
        nbits++;
        for (int i = 0; i < 3; i++) begin
          if ((nbits - seg[i] >= 4) &&
              ({bits[nbits-4], bits[nbits-3], bits[nbits-2], bits[nbits-1]} == pat_m))
            hit[i] = 1;
          if ((hit[i] != 0) && (ov[i] == 0)) seg[i] = nbits;
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (clr) cnt_m[i] = hit[i];
        else if ((hit[i] != 0) && (cnt_m[i] < cmax[i])) cnt_m[i]++;
        em[i] = hit[i];
      end
    end
    #1;
    chk("match_a", int'(match_a), em[0]);
    chk("match_b", int'(match_b), em[1]);
    chk("match_c", int'(match_c), em[2]);
    chk("cnt_a", int'(cnt_a), cnt_m[0]);
    chk("cnt_b", int'(cnt_b), cnt_m[1]);
    chk("cnt_c", int'(cnt_c), cnt_m[2]);
    chk("pat_a", int'(pat_a), int'(pat_m));
    chk("pat_b", int'(pat_b), int'(pat_m));
    chk("pat_c", int'(pat_c), int'(pat_m));
  endtask

  task automatic bit_in(input bit b);
    step(1'b0, 1'b1, b, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    bit s031 [7] = '{1, 1, 0, 1, 1, 0, 1};
    int e031 [7] = '{0, 0, 0, 1, 0, 0, 1};
    int e032 [7] = '{0, 0, 0, 1, 0, 0, 0};
    int e035 [5] = '{1, 2, 3, 3, 1};
    int mi;
    nbits = 0;
    pat_m = 4'b1101;
    for (int i = 0; i < 3; i++) begin
      seg[i] = 0; cnt_m[i] = 0; em[i] = 0;
    end

    // reset state
    do_reset();
    do_reset();
    chk("rst_pattern", int'(pat_a), 13);
    chk("rst_cnt", int'(cnt_a), 0);
    chk("rst_match", int'(match_a), 0);

    // overlapping vs non-overlapping on 1101101
    for (int k = 0; k < 7; k++) begin
      bit_in(s031[k]);
      chk("ovl_match", int'(match_a), e031[k]);
      chk("novl_match", int'(match_b), e032[k]);
    end
    chk("ovl_cnt", int'(cnt_a), 2);
    chk("novl_cnt", int'(cnt_b), 1);

    // en=0 gap keeps partial history
    do_reset();
    bit_in(1'b1); bit_in(1'b1); bit_in(1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 4'h0, 1'b0);
      chk("gap_nomatch", int'(match_a), 0);
    end
    bit_in(1'b1);
    chk("gap_match", int'(match_a), 1);

    // reset mid-sequence discards partial history
    do_reset();
    bit_in(1'b1); bit_in(1'b1); bit_in(1'b0);
    do_reset();
    bit_in(1'b1);
    chk("midrst_nomatch", int'(match_a), 0);

    // CNT_W=2 saturation and clear coinciding with the 5th match
    do_reset();
    mi = 0;
    for (int k = 0; k < 16; k++) begin
      bit b;
      b = (k == 0) ? 1'b1 : (((k - 1) % 3) != 1);
      step(1'b0, 1'b1, b, 1'b0, 4'h0, (k == 15));
      if (((k + 1) >= 4) && (((k + 1 - 4) % 3) == 0)) begin
        chk("sat_match", int'(match_c), 1);
        chk("sat_cnt", int'(cnt_c), e035[mi]);
        mi++;
      end
    end

    // pattern load with a concurrent valid bit; load-cycle bit discarded
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'b0011, 1'b0);
    chk("load_pattern", int'(pat_a), 3);
    chk("load_nomatch", int'(match_a), 0);
    bit_in(1'b0); bit_in(1'b0); bit_in(1'b1);
    chk("load_early", int'(match_a), 0);
    bit_in(1'b1);
    chk("load_match", int'(match_a), 1);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 75),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) < 5),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 99) < 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_detector.md
PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 SHALL have parameter PAT_LEN, default 4: pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter CNT_W, default 8: match counter width, legal range 1..32.
REQ-003 SHALL have parameter OVERLAP, default 1: 1 = overlapping matches, 0 = history restarts after each match.
REQ-004 SHALL have parameter PAT_RST, default 4'b1101 (PAT_LEN bits): pattern value after reset.
REQ-005 SHALL have port clk  input  1  clock, all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port en  input  1  x is a valid serial bit this cycle.
REQ-008 SHALL have port x  input  1  serial data bit.
REQ-009 SHALL have port pat_load  input  1  load pat_in as the new pattern.
REQ-010 SHALL have port pat_in  input  PAT_LEN  new pattern; bit PAT_LEN-1 is the first bit of the sequence.
REQ-011 SHALL have port clr_cnt  input  1  clear the match counter.
REQ-012 SHALL have port match  output  1  registered one-cycle pulse per detected pattern.
REQ-013 SHALL have port match_cnt  output  CNT_W  registered count of matches, saturating.
REQ-014 SHALL have port pattern  output  PAT_LEN  currently active pattern.

Function
REQ-015 SHALL keep history register hist (PAT_LEN-1 bits) and fill counter fill (0..PAT_LEN-1).
REQ-016 On en=1, SHALL form window W = {hist, x}; match condition = (fill == PAT_LEN-1) and (W == pattern).
REQ-017 On en=1 without match condition: hist <= lower PAT_LEN-1 bits of W; fill <= min(fill+1, PAT_LEN-1).
REQ-018 On en=1 with match condition and OVERLAP=1: hist and fill SHALL update per REQ-017.
REQ-019 On en=1 with match condition and OVERLAP=0: fill <= 0; hist contents are don't-care.
REQ-020 match SHALL be 1 in exactly the cycle after the en=1 cycle with match condition true, else 0; latency = 1 cycle.
REQ-021 en=0 SHALL leave hist and fill unchanged and x SHALL be ignored.
REQ-022 match_cnt SHALL increment by 1 on each match condition and saturate at 2^CNT_W-1 without wrapping.
REQ-023 pat_load=1 SHALL set pattern <= pat_in and fill <= 0 in the same edge.
REQ-024 pat_load=1 together with en=1: load wins, bit discarded, no match, match_cnt unaffected.
REQ-025 clr_cnt=1 SHALL set match_cnt <= 0.
REQ-026 clr_cnt=1 coinciding with a match condition SHALL set match_cnt <= 1, and match still pulses.
REQ-027 match_cnt SHALL be unaffected by pat_load.

Reset
REQ-028 rst=1 at a clock edge SHALL set pattern <= PAT_RST, hist <= 0, fill <= 0, match <= 0, match_cnt <= 0.
REQ-029 rst SHALL take priority over pat_load, clr_cnt and en, including mid-sequence: a partial sequence is discarded.
REQ-030 The first valid bit SHALL be accepted in the first cycle with rst=0.

Verification (PAT_LEN=4, CNT_W=8, pattern 1101 unless noted)
REQ-031 Stimulus: OVERLAP=1, bits 1,1,0,1,1,0,1 on consecutive en cycles. Response: match pulses after bits 4 and 7; match_cnt=2.
REQ-032 Stimulus: OVERLAP=0, same stream. Response: single match after bit 4; match_cnt=1.
REQ-033 Stimulus: bits 1,1,0 then en=0 for 5 cycles then bit 1. Response: no match during the gap; match one cycle after the final bit.
REQ-034 Stimulus: after bits 1,1,0, rst pulsed, then bit 1. Response: no match; fill restarts at 0.
REQ-035 Stimulus: CNT_W=2, 5 matches with a clr_cnt on the cycle of the 5th match. Response: match_cnt goes 1,2,3,3 then 1.
REQ-036 Stimulus: pat_load with pat_in=0011 on the cycle of a valid bit, then bits 0,0,1,1. Response: the load-cycle bit is discarded; pattern=0011; one match after the 4th bit.
